jtframe_wirebw_fir: RTL and testbench

Parametrised multi-channel horizontal FIR bandwidth filter for the video output path, sitting between the core's colour/sync outputs and the scaler/VGA stage. It emulates analogue cable bandwidth loss. It generalises the fixed 5-tap RGB filter:
- configurable tap count, channel count and widths;
- run-time coefficient loading with frame-synchronous bank swap;
- sync re-alignment to the centre tap;
- saturation and an overrun flag.

---
 rtl/jtframe_video_pkg.sv | 35 +++
 rtl/jtframe_wirebw_mac.sv | 74 +++++++
 rtl/jtframe_wirebw_fir.sv | 168 ++++++++++++++++
 tb/tb_jtframe_wirebw_fir.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_video_pkg.sv
// Shared helpers for the jtframe video path: width extension, clog2, accumulator
// sizing, the default 5-tap cable-bandwidth kernel and the MAC sequencer states.
package jtframe_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } mac_st_e;

  localparam logic [24:0] COEFF_5TAP = {5'd0, 5'd7, 5'd20, 5'd7, 5'd0};

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned aw_calc(input int unsigned win, input int unsigned wc,
                                          input int unsigned n);
    return win + wc + clog2(n);
  endfunction

  // Widen win bits to wout by repeating the top (wout-win) bits below the value
  function automatic logic [31:0] ext(input logic [31:0] a, input int unsigned win,
                                      input int unsigned wout);
    logic [31:0] m;
    m = a & ((32'd1 << win) - 32'd1);
    return (m << (wout - win)) | (m >> (2 * win - wout));
  endfunction

endpackage

// File: rtl/jtframe_wirebw_mac.sv
// One colour channel of the wire-bandwidth FIR: sample history, sequential
// multiply-accumulate driven by the shared tap index, scaling and saturation.
module jtframe_wirebw_mac
  import jtframe_video_pkg::*;
#(
  parameter int unsigned WIN  = 4,
  parameter int unsigned WOUT = 5,
  parameter int unsigned WC   = 5,
  parameter int unsigned N    = 5,
  parameter int unsigned SW   = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            spl_i,
  input  logic            mac_en_i,
  input  logic [SW-1:0]   tap_i,
  input  logic [WC-1:0]   coef_i,
  input  logic [WIN-1:0]  din_i,
  output logic [WOUT-1:0] dout_o
);

  localparam int unsigned AW = aw_calc(WIN, WC, N);
  localparam int unsigned SH = WC - (WOUT - WIN);
  localparam int unsigned PW = WIN + WC;

  logic [WIN-1:0]  hist_q [N];
  logic [WIN-1:0]  hist_d [N];
  logic [AW-1:0]   acc_q, acc_d;
  logic [WOUT-1:0] dout_q, dout_d;
  logic [WIN-1:0]  sel;
  logic [PW-1:0]   prod;
  logic [AW-1:0]   shifted;
  logic [WOUT-1:0] res;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(tap_i) == i) sel = hist_q[i];
    end
    prod    = PW'(sel) * PW'(coef_i);
    shifted = acc_q >> SH;
    res     = (|shifted[AW-1:WOUT]) ? '1 : shifted[WOUT-1:0];
  end

  always_comb begin
    hist_d = hist_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    if (spl_i) begin
      hist_d[0] = din_i;
      for (int unsigned i = 1; i < N; i++) hist_d[i] = hist_q[i-1];
      // an unfinished MAC (overrun) still hands over its partial sum
      dout_d = res;
      acc_d  = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N; i++) hist_q[i] <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      hist_q <= hist_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/jtframe_wirebw_fir.sv
// Multi-channel horizontal FIR emulating analogue cable bandwidth, with sync
// re-alignment and overrun flag. Define JTFRAME_WIREBW_COEFLOAD_EN for run-time
// coefficient loading with a frame-synchronous shadow/active bank swap.
module jtframe_wirebw_fir
  import jtframe_video_pkg::*;
#(
  parameter int unsigned WIN  = 4,
  parameter int unsigned WOUT = 5,
  parameter int unsigned WC   = 5,
  parameter int unsigned N    = 5,
  parameter int unsigned CH   = 3,
  parameter logic [N*WC-1:0] COEFF = COEFF_5TAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce_pix,
  input  logic                    enable,
  input  logic [CH*WIN-1:0]       din,
  input  logic                    HS_in,
  input  logic                    VS_in,
  input  logic                    HB_in,
  input  logic                    VB_in,
  input  logic                    coef_we,
  input  logic [clog2(N)-1:0]     coef_addr,
  input  logic [WC-1:0]           coef_din,
  output logic [CH*WOUT-1:0]      dout,
  output logic                    HS_out,
  output logic                    VS_out,
  output logic                    HB_out,
  output logic                    VB_out,
  output logic                    ovf
);

  localparam int unsigned SW = clog2(N);
  localparam int unsigned D  = (N + 1) / 2;

  logic          ce_last_q, spl_q;
  mac_st_e       st_q, st_d;
  logic [SW-1:0] step_q, step_d;
  logic          mac_en, ovf_set, ovf_q;
  logic [WC-1:0] coef_cur;
  logic [3:0]    sync_q [D+1];
  logic [WOUT-1:0] dout_reg [CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_last_q <= 1'b0;
      spl_q     <= 1'b0;
    end else begin
      ce_last_q <= ce_pix;
      spl_q     <= ce_pix & ~ce_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      step_q <= '0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    if (spl_q) begin
      st_d   = ST_MAC;
      step_d = '0;
    end else begin
      case (st_q)
        ST_MAC: begin
          if (step_q == SW'(N - 1)) st_d = ST_DONE;
          else step_d = step_q + 1'b1;
        end
        ST_DONE: st_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    mac_en  = (st_q == ST_MAC) && !spl_q;
    ovf_set = (st_q == ST_MAC) && spl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

`ifdef JTFRAME_WIREBW_COEFLOAD_EN
  logic [WC-1:0] shadow_q [N];
  logic [WC-1:0] active_q [N];
  logic          vb_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        shadow_q[i] <= COEFF[i*WC +: WC];
        active_q[i] <= COEFF[i*WC +: WC];
      end
      vb_prev_q <= 1'b0;
    end else begin
      if (spl_q) begin
        vb_prev_q <= VB_in;
        if (VB_in && !vb_prev_q) active_q <= shadow_q;
      end
      // copy above reads the old shadow, so a same-clk write waits a frame
      if (coef_we && (32'(coef_addr) < N)) shadow_q[coef_addr] <= coef_din;
    end
  end

  always_comb begin
    coef_cur = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(step_q) == i) coef_cur = active_q[i];
    end
  end
`else
  logic unused_coef;
  assign unused_coef = ^{coef_we, coef_addr, coef_din};

  always_comb begin
    coef_cur = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(step_q) == i) coef_cur = COEFF[i*WC +: WC];
    end
  end
`endif

  // capture stage plus (N+1)/2 delays lines syncs up with the registered centre tap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= D; i++) sync_q[i] <= '0;
    end else if (spl_q) begin
      sync_q[0] <= {VB_in, HB_in, VS_in, HS_in};
      for (int unsigned i = 1; i <= D; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    jtframe_wirebw_mac #(
      .WIN  (WIN),
      .WOUT (WOUT),
      .WC   (WC),
      .N    (N),
      .SW   (SW)
    ) u_mac (
      .clk_i    (clk),
      .rst_i    (rst),
      .spl_i    (spl_q),
      .mac_en_i (mac_en),
      .tap_i    (step_q),
      .coef_i   (coef_cur),
      .din_i    (din[c*WIN +: WIN]),
      .dout_o   (dout_reg[c])
    );

    assign dout[c*WOUT +: WOUT] = enable ? dout_reg[c]
                                         : WOUT'(ext(32'(din[c*WIN +: WIN]), WIN, WOUT));
  end

  assign {VB_out, HB_out, VS_out, HS_out} = enable ? sync_q[D] : {VB_in, HB_in, VS_in, HS_in};
  assign ovf = ovf_q;

endmodule

// File: tb/tb_jtframe_wirebw_fir.sv
// Bench for jtframe_wirebw_fir: behavioural FIR model checked every cycle, plus
// hand-computed literal expectations on impulse, flat field, bypass, banks, overrun.
module tb_jtframe_wirebw_fir;

  localparam int unsigned WIN  = 4;
  localparam int unsigned WOUT = 5;
  localparam int unsigned WC   = 5;
  localparam int unsigned N    = 5;
  localparam int unsigned CH   = 3;
  localparam int unsigned SH   = WC - (WOUT - WIN);
  localparam int unsigned OMAX = (1 << WOUT) - 1;
`ifdef JTFRAME_WIREBW_COEFLOAD_EN
  localparam bit LOAD = 1'b1;
`else
  localparam bit LOAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce_pix = 1'b0;
  logic              enable = 1'b1;
  logic [CH*WIN-1:0] din = '0;
  logic              HS_in = 1'b0, VS_in = 1'b0, HB_in = 1'b0, VB_in = 1'b0;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic [WC-1:0]     coef_din = '0;
  logic [CH*WOUT-1:0] dout;
  logic              HS_out, VS_out, HB_out, VB_out, ovf;

  jtframe_wirebw_fir #(
    .WIN  (WIN),
    .WOUT (WOUT),
    .WC   (WC),
    .N    (N),
    .CH   (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_pix    (ce_pix),
    .enable    (enable),
    .din       (din),
    .HS_in     (HS_in),
    .VS_in     (VS_in),
    .HB_in     (HB_in),
    .VB_in     (VB_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_din  (coef_din),
    .dout      (dout),
    .HS_out    (HS_out),
    .VS_out    (VS_out),
    .HB_out    (HB_out),
    .VB_out    (VB_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_hist [CH][N];
  int unsigned m_dreg [CH];
  int unsigned m_act [N];
  int unsigned m_shd [N];
  int unsigned m_steps;
  bit          m_ce_prev, m_spl_pend, m_spl_now, m_started, m_vb_prev, m_ovf;
  bit [3:0]    m_sq [$];
  int unsigned m_sum;

  function automatic int unsigned ext_m(input int unsigned a);
    return (a << (WOUT - WIN)) | (a >> (2 * WIN - WOUT));
  endfunction

  task automatic m_reset();
    int unsigned dflt [N];
    dflt = '{0, 7, 20, 7, 0};
    for (int c = 0; c < CH; c++) begin
      m_dreg[c] = 0;
      for (int j = 0; j < N; j++) m_hist[c][j] = 0;
    end
    for (int j = 0; j < N; j++) begin
      m_act[j] = dflt[j];
      m_shd[j] = dflt[j];
    end
    m_steps = 0; m_ce_prev = 0; m_spl_pend = 0; m_started = 0;
    m_vb_prev = 0; m_ovf = 0;
    m_sq.delete();
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
    end else begin
      m_spl_now  = m_spl_pend;
      m_spl_pend = ce_pix && !m_ce_prev;
      m_ce_prev  = ce_pix;
      if (m_spl_now) begin
        if (m_started && m_steps < N) m_ovf = 1;
        for (int c = 0; c < CH; c++) begin
          m_sum = 0;
          for (int j = 0; j < N; j++)
            if (j < m_steps) m_sum += m_act[j] * m_hist[c][j];
          m_sum = m_sum >> SH;
          m_dreg[c] = (m_sum > OMAX) ? OMAX : m_sum;
        end
        if (LOAD && VB_in && !m_vb_prev) m_act = m_shd;
        m_vb_prev = VB_in;
        for (int c = 0; c < CH; c++) begin
          for (int j = N - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
          m_hist[c][0] = (din >> (c * WIN)) & ((1 << WIN) - 1);
        end
        m_sq.push_back({VB_in, HB_in, VS_in, HS_in});
        if (m_sq.size() > 8) void'(m_sq.pop_front());
        m_started = 1;
        m_steps = 0;
      end else if (m_started && m_steps < N) begin
        m_steps++;
      end
      if (LOAD && coef_we && coef_addr < N) m_shd[coef_addr] = coef_din;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned e;
      bit [3:0] es;
      for (int c = 0; c < CH; c++) begin
        e = enable ? m_dreg[c] : ext_m((din >> (c * WIN)) & ((1 << WIN) - 1));
        chk($sformatf("dout_ch%0d", c), (dout >> (c * WOUT)) & OMAX, e);
      end
      if (enable) es = (m_sq.size() >= 4) ? m_sq[m_sq.size() - 4] : 4'b0;
      else        es = {VB_in, HB_in, VS_in, HS_in};
      chk("syncs", {VB_out, HB_out, VS_out, HS_out}, es);
      chk("ovf", ovf, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pixw(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                      input logic [3:0] s, input int unsigned nclk,
                      input bit we, input logic [2:0] wa, input logic [4:0] wv);
    din = {v2, v1, v0};
    {VB_in, HB_in, VS_in, HS_in} = s;
    ce_pix = 1'b1;
    @(posedge clk); #2;
    ce_pix = 1'b0;
    if (we) begin
      coef_we = 1'b1; coef_addr = wa; coef_din = wv;
    end
    @(posedge clk); #2;
    coef_we = 1'b0;
    repeat (nclk - 2) @(posedge clk);
    #2;
  endtask

  task automatic pix(input logic [3:0] v, input logic [3:0] s, input int unsigned nclk);
    pixw(v, v, v, s, nclk, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] v);
    coef_we = 1'b1; coef_addr = a; coef_din = v;
    @(posedge clk); #2;
    coef_we = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic impulse(input string tag);
    int unsigned exp0 [6];
    bit          exph [6];
    exp0 = '{0, 0, 6, 18, 6, 0};
    exph = '{0, 0, 0, 1, 0, 0};
    pix(4'd0, 4'd0, 8); pix(4'd0, 4'd0, 8);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) pixw(4'd15, 4'd8, 4'd0, 4'b0001, 8, 1'b0, 3'd0, 5'd0);
      else        pix(4'd0, 4'd0, 8);
      chk($sformatf("%s_ch0_s%0d", tag, i), dout[4:0], exp0[i]);
      chk($sformatf("%s_hs_s%0d", tag, i), HS_out, exph[i]);
      if (i == 3) chk($sformatf("%s_ch1_peak", tag), dout[9:5], 10);
    end
  endtask

  initial begin
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("reset_dout", dout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_hs", HS_out, 0);

    impulse("imp1");

    // bypass: combinational extension, zero-delay syncs, history keeps moving
    enable = 1'b0;
    din = {4'd15, 4'd0, 4'hA};
    #1 chk("byp_ch0", dout[4:0], 5'h15);
    chk("byp_ch2", dout[14:10], 31);
    HS_in = 1'b1;
    #1 chk("byp_hs", HS_out, 1);
    HS_in = 1'b0;
    for (int i = 0; i < 3; i++) pix(4'(i * 5 + 1), 4'b0, 8);
    enable = 1'b1;
    pix(4'd9, 4'b0, 8);

    // flat fields with default kernel (sum 34)
    for (int i = 0; i < 6; i++) pix(4'd15, 4'b0, 8);
    chk("flat15", dout[4:0], 31);
    for (int i = 0; i < 6; i++) pix(4'd10, 4'b0, 8);
    chk("flat10", dout[4:0], 21);

    // bank swap on VB rising edge
    wr(3'd0, 5'd0); wr(3'd1, 5'd0); wr(3'd2, 5'd16); wr(3'd3, 5'd0); wr(3'd4, 5'd0);
    wr(3'd5, 5'd31);
    pix(4'd10, 4'b0000, 8); pix(4'd10, 4'b0000, 8);
    chk("swap_pre", dout[4:0], 21);
    pixw(4'd10, 4'd10, 4'd10, 4'b1000, 8, 1'b1, 3'd2, 5'd0);
    chk("swap_edge", dout[4:0], 21);
    pix(4'd10, 4'b1000, 8);
    chk("swap_new", dout[4:0], LOAD ? 10 : 21);
    pix(4'd10, 4'b1000, 8); pix(4'd10, 4'b0000, 8);
    chk("swap_hold", dout[4:0], LOAD ? 10 : 21);
    pix(4'd10, 4'b1000, 8); pix(4'd10, 4'b1000, 8);
    chk("swap_deferred", dout[4:0], LOAD ? 0 : 21);

    // saturation with an all-31 kernel (acc 2325 >> 4 = 145 -> 31)
    for (int a = 0; a < 5; a++) wr(3'(a), 5'd31);
    pix(4'd15, 4'b0000, 8); pix(4'd15, 4'b1000, 8);
    for (int i = 0; i < 6; i++) pix(4'd15, 4'b1000, 8);
    chk("sat", dout[4:0], 31);

    // overrun: 4 clk pixel period
    do_rst();
    pix(4'd7, 4'b0, 4);
    chk("ovf_first", ovf, 0);
    pix(4'd7, 4'b0, 4);
    chk("ovf_second", ovf, 1);
    pix(4'd7, 4'b0, 4); pix(4'd7, 4'b0, 8);
    chk("ovf_sticky", ovf, 1);

    // reset two clocks after a strobe
    din = {4'd5, 4'd5, 4'd5};
    ce_pix = 1'b1;
    @(posedge clk); #2 ce_pix = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("midmac_dout", dout, 0);
    chk("midmac_ovf", ovf, 0);

    impulse("imp2");

    repeat (4) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
